cpu_exec_ctrl: RTL and testbench
================================

Name: cpu_exec_ctrl

Overview:
- Execution sequencer for the 5-stage MIPS32 pipeline.
- Accepts commands from the debug/UART unit: run, step N cycles, stop, flush.
- Drives the global pipeline enable that gates every pipeline register, PC and register file.
- Tracks the halt instruction retiring in WB, and keeps an executed-cycle counter for the debug dump.

Parameters:
- STEP_W, 16, width of step-count field.
- CYC_W, 32, width of executed-cycle counter.
- FLUSH_CYCLES, 5, cycles o_pipeline_flush stays high after a FLUSH command (pipeline depth); must be >=1.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  controller can consume a command this cycle.
- i_cmd  in  2  command code: 00 RUN, 01 STEP, 10 STOP, 11 FLUSH.
- i_step_count  in  STEP_W  STEP length in cycles; sampled with STEP.
- i_halt_wb  in  1  HALT instruction is in WB this cycle (qualified by enable).
- o_cpu_enable  out  1  pipeline advance enable.
- o_pipeline_flush  out  1  clears all pipeline registers and PC.
- o_busy  out  1  state not IDLE.
- o_done  out  1  one-cycle pulse when a RUN/STEP/FLUSH completes.
- o_halted  out  1  sticky: HALT has retired since last FLUSH.
- o_cycle_count  out  CYC_W  enabled cycles since last FLUSH/reset.
- o_state  out  3  encoded state for the debug dump.

Behaviour:
- Reset (i_reset==0 at a rising edge) returns all state to reset values, also mid-RUN/STEP/FLUSH:
  - state IDLE; step counter, flush counter and cycle counter 0; o_halted 0.
  - Outputs after reset: o_cpu_enable 0, o_pipeline_flush 0, o_done 0, o_busy 0, o_cmd_ready 1.
- States and encodings: IDLE=0, RUN=1, STEP=2, FLUSH=3, DONE=4. All outputs are decoded from registered state; no comb path from i_cmd to outputs.
- Handshake:
  - A command transfers on the edge where i_cmd_valid and o_cmd_ready are both high.
  - o_cmd_ready = state in {IDLE, RUN, STEP}.
  - In RUN/STEP only STOP has effect; other accepted codes are consumed and dropped.
  - In IDLE, STOP is consumed with no effect.
- IDLE:
  - RUN -> RUN.
  - STEP -> STEP, step counter loaded with i_step_count; value 0 is loaded as 1.
  - FLUSH -> FLUSH, flush counter loaded with FLUSH_CYCLES.
  - If o_halted==1, RUN and STEP go directly to DONE (zero enabled cycles).
- RUN:
  - o_cpu_enable=1.
  - i_halt_wb -> DONE and set o_halted. The halt cycle itself is enabled, so the HALT commits.
  - STOP accepted -> DONE. Enable drops on the cycle after acceptance.
- STEP:
  - o_cpu_enable=1; step counter decrements each cycle.
  - Counter==1 -> DONE, giving exactly N enabled cycles.
  - i_halt_wb or STOP -> DONE early; halt sets o_halted.
  - Counter==1 and halt in the same cycle: DONE, o_halted set.
  - STOP and halt in the same cycle: DONE, o_halted set.
- FLUSH:
  - o_pipeline_flush=1, o_cpu_enable=0.
  - Cycle counter and o_halted cleared on entry.
  - Counter decrements; at 1 -> DONE. Flush is high exactly FLUSH_CYCLES cycles.
- DONE: o_done=1 for one cycle, o_cmd_ready=0, then -> IDLE.
- Cycle counter: +1 on every cycle with o_cpu_enable=1; wraps modulo 2^CYC_W.
- Command-accept to first enabled cycle latency: 1 cycle.

Test Plan:
- Reset then idle 10 cycles -> o_cpu_enable 0, o_cmd_ready 1, o_cycle_count 0, o_state 0.
- STEP with count 7 -> enable high exactly 7 consecutive cycles, o_done pulses once on the following cycle, o_cycle_count=7; repeat with count 0 -> exactly 1 enabled cycle, count=8.
- RUN, i_halt_wb pulsed on the 20th enabled cycle -> 20 enabled cycles total, o_halted=1, o_done pulse. A subsequent RUN -> DONE immediately, 0 enabled cycles, count unchanged.
- RUN, then STOP accepted after 12 enabled cycles -> enable low next cycle, count=13, o_halted=0. A STEP issued during RUN is consumed with no effect.
- FLUSH after a halt -> o_pipeline_flush high exactly 5 cycles, enable 0 throughout, o_halted and o_cycle_count cleared, o_done pulse; a RUN then executes normally.
- i_reset low mid-STEP (count 100, 40 done) -> next cycle state IDLE, enable 0, count 0, ready 1. Also STEP count 3 with halt on the 3rd enabled cycle -> DONE with o_halted=1.

Source files
------------

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: execution sequencer for the 5-stage MIPS32 pipeline.
// Consumes RUN / STEP / STOP / FLUSH commands from the debug unit, drives the
// global pipeline enable and flush, tracks HALT retirement and counts enabled
// cycles for the debug dump.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd, i_step_count   command handshake
//   i_halt_wb            HALT instruction in WB this cycle
//   o_cpu_enable         pipeline advance enable
//   o_pipeline_flush     clears pipeline registers and PC
//   o_busy, o_done       status: not idle / one-cycle completion pulse
//   o_halted             sticky HALT-retired flag, cleared by FLUSH
//   o_cycle_count        enabled cycles since last FLUSH/reset
//   o_state              encoded state for the debug dump
module cpu_exec_ctrl #(
    parameter int unsigned STEP_W       = 16,
    parameter int unsigned CYC_W        = 32,
    parameter int unsigned FLUSH_CYCLES = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd,
    input  logic [STEP_W-1:0] i_step_count,
    input  logic              i_halt_wb,
    output logic              o_cpu_enable,
    output logic              o_pipeline_flush,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_halted,
    output logic [CYC_W-1:0]  o_cycle_count,
    output logic [2:0]        o_state
);

    localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] CmdRun   = 2'b00;
    localparam logic [1:0] CmdStep  = 2'b01;
    localparam logic [1:0] CmdStop  = 2'b10;
    localparam logic [1:0] CmdFlush = 2'b11;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StStep  = 3'd2,
        StFlush = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               halted_q, halted_d;
    logic               cmd_fire;
    logic               stop_fire;

    assign cmd_fire  = i_cmd_valid & o_cmd_ready;
    assign stop_fire = cmd_fire & (i_cmd == CmdStop);

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q  <= StIdle;
            step_q   <= '0;
            flush_q  <= '0;
            cyc_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            flush_q  <= flush_d;
            cyc_q    <= cyc_d;
            halted_q <= halted_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        flush_d  = flush_q;
        cyc_d    = cyc_q;
        halted_d = halted_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    unique case (i_cmd)
                        CmdRun: state_d = halted_q ? StDone : StRun;
                        CmdStep: begin
                            state_d = halted_q ? StDone : StStep;
                            step_d  = (i_step_count == '0) ? STEP_W'(1) : i_step_count;
                        end
                        CmdFlush: begin
                            state_d  = StFlush;
                            flush_d  = FLUSH_W'(FLUSH_CYCLES);
                            cyc_d    = '0;
                            halted_d = 1'b0;
                        end
                        default: ; // STOP while idle is consumed with no effect
                    endcase
                end
            end
            StRun: begin
                cyc_d = cyc_q + CYC_W'(1);
                // The halt cycle is still enabled so the HALT itself commits.
                if (i_halt_wb) begin
                    state_d  = StDone;
                    halted_d = 1'b1;
                end else if (stop_fire) begin
                    state_d = StDone;
                end
            end
            StStep: begin
                cyc_d  = cyc_q + CYC_W'(1);
                step_d = step_q - STEP_W'(1);
                if (i_halt_wb) begin
                    halted_d = 1'b1;
                end
                if (i_halt_wb || stop_fire || (step_q == STEP_W'(1))) begin
                    state_d = StDone;
                end
            end
            StFlush: begin
                flush_d = flush_q - FLUSH_W'(1);
                if (flush_q == FLUSH_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        o_cpu_enable     = (state_q == StRun) || (state_q == StStep);
        o_pipeline_flush = (state_q == StFlush);
        o_busy           = (state_q != StIdle);
        o_done           = (state_q == StDone);
        o_cmd_ready      = (state_q == StIdle) || (state_q == StRun) || (state_q == StStep);
        o_halted         = halted_q;
        o_cycle_count    = cyc_q;
        o_state          = state_q;
    end

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Self-checking bench for cpu_exec_ctrl: directed scenarios plus randomized
// RUN/STEP/FLUSH sequences checked against a transaction-level model.
module tb_cpu_exec_ctrl;

    localparam int unsigned STEP_W       = 16;
    localparam int unsigned CYC_W        = 32;
    localparam int unsigned FLUSH_CYCLES = 5;

    localparam logic [1:0] CmdRun   = 2'b00;
    localparam logic [1:0] CmdStep  = 2'b01;
    localparam logic [1:0] CmdStop  = 2'b10;
    localparam logic [1:0] CmdFlush = 2'b11;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd;
    logic [STEP_W-1:0] step_count;
    logic              halt_wb;
    logic              cpu_enable;
    logic              pipeline_flush;
    logic              busy;
    logic              done;
    logic              halted;
    logic [CYC_W-1:0]  cycle_count;
    logic [2:0]        state;

    int errors = 0;
    int checks = 0;

    // Transaction-level model state
    logic [CYC_W-1:0] exp_cycles;
    bit               exp_halted;

    cpu_exec_ctrl #(
        .STEP_W       (STEP_W),
        .CYC_W        (CYC_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_cmd            (cmd),
        .i_step_count     (step_count),
        .i_halt_wb        (halt_wb),
        .o_cpu_enable     (cpu_enable),
        .o_pipeline_flush (pipeline_flush),
        .o_busy           (busy),
        .o_done           (done),
        .o_halted         (halted),
        .o_cycle_count    (cycle_count),
        .o_state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] c, input int cnt, input string name);
        int g = 0;
        while (cmd_ready !== 1'b1 && g < 50) begin
            tick();
            g++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready-timeout: got ready=%b want 1", name, cmd_ready);
        end
        cmd_valid  = 1'b1;
        cmd        = c;
        step_count = STEP_W'(cnt);
        tick();
        cmd_valid  = 1'b0;
    endtask

    // Expected enabled cycles and halt outcome from the command rules.
    task automatic model_exec(input logic [1:0] c, input int cnt, input int halt_at,
                              input int stop_at, output int en, output bit h);
        int limit;
        if (exp_halted) begin
            en = 0;
            h  = 1'b1;
            return;
        end
        limit = (c == CmdStep) ? ((cnt == 0) ? 1 : cnt) : 1000000;
        if (stop_at > 0 && stop_at < limit) limit = stop_at;
        if (halt_at > 0 && halt_at <= limit) begin
            en = halt_at;
            h  = 1'b1;
        end else begin
            en = limit;
            h  = 1'b0;
        end
    endtask

    // Issue RUN/STEP, inject halt/stop/dropped command on given enabled cycle,
    // then check enabled-cycle count and the completion sequence.
    task automatic exec(input logic [1:0] c, input int cnt, input int halt_at,
                        input int stop_at, input int drop_at, input string name);
        int en = 0;
        int guard = 0;
        int exp_en;
        bit exp_h;
        model_exec(c, cnt, halt_at, stop_at, exp_en, exp_h);
        issue(c, cnt, name);
        while (cpu_enable === 1'b1 && guard < 400) begin
            en++;
            guard++;
            halt_wb = (en == halt_at);
            if (en == stop_at) begin
                cmd_valid = 1'b1;
                cmd       = CmdStop;
            end else if (en == drop_at) begin
                cmd_valid  = 1'b1;
                cmd        = CmdStep;
                step_count = STEP_W'(2);
            end
            tick();
            halt_wb   = 1'b0;
            cmd_valid = 1'b0;
        end
        exp_cycles = exp_cycles + CYC_W'(exp_en);
        exp_halted = exp_h;
        checks++;
        if (en != exp_en) begin
            errors++;
            $display("FAIL %s enabled-cycles: got %0d want %0d", name, en, exp_en);
        end
        checks++;
        if (done !== 1'b1 || state !== 3'd4 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done-phase: got done=%b state=%0d ready=%b want 1 4 0",
                     name, done, state, cmd_ready);
        end
        checks++;
        if (halted !== exp_halted) begin
            errors++;
            $display("FAIL %s halted: got %b want %b", name, halted, exp_halted);
        end
        checks++;
        if (cycle_count !== exp_cycles) begin
            errors++;
            $display("FAIL %s cycle-count: got %0d want %0d", name, cycle_count, exp_cycles);
        end
        tick();
        checks++;
        if (done !== 1'b0 || state !== 3'd0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s back-to-idle: got done=%b state=%0d ready=%b busy=%b want 0 0 1 0",
                     name, done, state, cmd_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_cycles = '0;
        exp_halted = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (cpu_enable !== 1'b0 || cmd_ready !== 1'b1 || cycle_count !== '0 ||
                state !== 3'd0 || done !== 1'b0 || pipeline_flush !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset-idle: got en=%b rdy=%b cnt=%0d st=%0d want 0 1 0 0",
                         cpu_enable, cmd_ready, cycle_count, state);
            end
        end
    endtask

    task automatic test_flush(input string name);
        int fl = 0;
        int guard = 0;
        issue(CmdFlush, 0, name);
        exp_cycles = '0;
        exp_halted = 1'b0;
        while (pipeline_flush === 1'b1 && guard < 50) begin
            fl++;
            guard++;
            checks++;
            if (cpu_enable !== 1'b0 || halted !== 1'b0 || cycle_count !== '0) begin
                errors++;
                $display("FAIL %s in-flush: got en=%b halted=%b cnt=%0d want 0 0 0",
                         name, cpu_enable, halted, cycle_count);
            end
            tick();
        end
        checks++;
        if (fl != FLUSH_CYCLES) begin
            errors++;
            $display("FAIL %s flush-length: got %0d want %0d", name, fl, FLUSH_CYCLES);
        end
        checks++;
        if (done !== 1'b1 || state !== 3'd4) begin
            errors++;
            $display("FAIL %s flush-done: got done=%b state=%0d want 1 4", name, done, state);
        end
        tick();
        checks++;
        if (done !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL %s flush-idle: got done=%b state=%0d want 0 0", name, done, state);
        end
    endtask

    task automatic test_step();
        exec(CmdStep, 7, 0, 0, 0, "step7");
        exec(CmdStep, 0, 0, 0, 0, "step0");
    endtask

    task automatic test_halt_run();
        exec(CmdRun, 0, 20, 0, 0, "run-halt20");
        exec(CmdRun, 0, 0, 5, 0, "run-while-halted");
    endtask

    task automatic test_stop_run();
        exec(CmdRun, 0, 0, 13, 5, "run-stop");
        exec(CmdStep, 3, 3, 0, 0, "step3-halt3");
    endtask

    task automatic test_reset_mid_step();
        test_flush("pre-reset-flush");
        issue(CmdStep, 100, "reset-mid-step");
        for (int i = 0; i < 40; i++) begin
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cycles = '0;
        exp_halted = 1'b0;
        checks++;
        if (state !== 3'd0 || cpu_enable !== 1'b0 || cycle_count !== '0 ||
            cmd_ready !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset-mid-step: got st=%0d en=%b cnt=%0d rdy=%b halted=%b want 0 0 0 1 0",
                     state, cpu_enable, cycle_count, cmd_ready, halted);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int op = $urandom_range(0, 9);
            int cnt = $urandom_range(0, 15);
            int h = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
            int s = $urandom_range(1, 30);
            if (op == 0) begin
                test_flush("rand-flush");
            end else if (op < 5) begin
                exec(CmdStep, cnt, h, ($urandom_range(0, 3) == 0) ? s : 0, 0, "rand-step");
            end else begin
                exec(CmdRun, 0, h, s, ($urandom_range(0, 1) == 0) ? 2 : 0, "rand-run");
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd        = CmdRun;
        step_count = '0;
        halt_wb    = 1'b0;
        exp_cycles = '0;
        exp_halted = 1'b0;
        test_reset();
        test_step();
        test_halt_run();
        test_flush("flush-after-halt");
        test_stop_run();
        test_reset_mid_step();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
